// File: rtl/ssc_dsd_stream_encoder_pkg.sv
// Shared types, field constants and constant-alpha helpers for the SSC-DSD
// Reed-Solomon stream encoder over GF(2^8), primitive polynomial 0x15F.
package ssc_dsd_pkg;

   localparam int unsigned SYM_W       = 8;
   localparam int unsigned DATA_SYMS   = 36;
   localparam int unsigned PARITY_SYMS = 3;
   localparam int unsigned CW_SYMS     = 39;
   localparam logic [8:0]  GF_POLY     = 9'h15F;

   typedef logic [7:0] sym_t;

   typedef enum logic [0:0] {
      DATA,
      PARITY
   } enc_state_e;

   function automatic sym_t gf_mul_alpha(input sym_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
   endfunction

   function automatic sym_t gf_mul_alpha2(input sym_t a);
      return gf_mul_alpha(gf_mul_alpha(a));
   endfunction

endpackage

// File: rtl/ssc_dsd_stream_encoder_if.sv
// Data-in / codeword-out handshake bundle of the SSC-DSD stream encoder.
interface ssc_dsd_stream_encoder_if;
   import ssc_dsd_pkg::*;

   sym_t       Data_in;
   logic       Data_valid_in;
   logic       Data_ready_out;
   sym_t       Code_out;
   logic [5:0] Code_index_out;
   logic       Code_valid_out;
   logic       Code_ready_in;
   logic       Code_last_out;
   logic       Busy_out;

   modport master (
      output Data_in, Data_valid_in, Code_ready_in,
      input  Data_ready_out, Code_out, Code_index_out, Code_valid_out,
             Code_last_out, Busy_out
   );

   modport slave (
      input  Data_in, Data_valid_in, Code_ready_in,
      output Data_ready_out, Code_out, Code_index_out, Code_valid_out,
             Code_last_out, Busy_out
   );
endinterface

// File: rtl/ssc_dsd_stream_encoder_gf_mul.sv
// Combinational general GF(2^8) multiplier (shift-and-add, reduced by 0x15F).
module gf_mul
   import ssc_dsd_pkg::*;
(
   input  sym_t a_i,
   input  sym_t b_i,
   output sym_t p_o
);

   sym_t acc;
   sym_t sh;

   always_comb begin
      acc = '0;
      sh  = a_i;
      for (int unsigned i = 0; i < SYM_W; i++) begin
         if (b_i[i]) acc = acc ^ sh;
         sh = gf_mul_alpha(sh);
      end
      p_o = acc;
   end

endmodule

// File: rtl/ssc_dsd_stream_encoder.sv
// Streaming systematic SSC-DSD RS encoder: forwards DATA_SYMS data symbols,
// then appends parity P0..P2 at codeword indices 36..38.
module ssc_dsd_stream_encoder #(
   parameter int unsigned DATA_SYMS = ssc_dsd_pkg::DATA_SYMS
) (
   input logic                     clk,
   input logic                     rst_n,
   input logic                     Clear_in,
   ssc_dsd_stream_encoder_if.slave bus
);
   import ssc_dsd_pkg::*;

   localparam logic [5:0] LAST_CNT = 6'(DATA_SYMS - 1);
   localparam logic [5:0] PAR_IDX0 = 6'(CW_SYMS - PARITY_SYMS);

   enc_state_e state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   sym_t       acc0_q, acc0_d, acc1_q, acc1_d, acc2_q, acc2_d;
   sym_t       w1_q, w1_d, w2_q, w2_d;
   logic [1:0] psel_q, psel_d;
   sym_t       code_q, code_d;
   logic [5:0] idx_q, idx_d;
   logic       valid_q, valid_d, last_q, last_d, busy_q, busy_d;

   sym_t prod1, prod2, par_sym;
   logic free, fire, data_ready;

   gf_mul u_mul_w1 (.a_i(bus.Data_in), .b_i(w1_q), .p_o(prod1));
   gf_mul u_mul_w2 (.a_i(bus.Data_in), .b_i(w2_q), .p_o(prod2));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc0_d     = acc0_q;
      acc1_d     = acc1_q;
      acc2_d     = acc2_q;
      w1_d       = w1_q;
      w2_d       = w2_q;
      psel_d     = psel_q;
      code_d     = code_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      last_d     = last_q;
      busy_d     = busy_q;
      data_ready = 1'b0;
      free       = !valid_q | bus.Code_ready_in;
      fire       = valid_q & bus.Code_ready_in;

      unique case (psel_q)
         2'd0:    par_sym = acc0_q;
         2'd1:    par_sym = acc1_q;
         default: par_sym = acc2_q;
      endcase

      if (fire) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      unique case (state_q)
         DATA: begin
            data_ready = free;
            if (bus.Data_valid_in && free) begin
               code_d  = bus.Data_in;
               idx_d   = cnt_q;
               valid_d = 1'b1;
               last_d  = 1'b0;
               busy_d  = 1'b1;
               acc0_d  = acc0_q ^ bus.Data_in;
               acc1_d  = acc1_q ^ prod1;
               acc2_d  = acc2_q ^ prod2;
               w1_d    = gf_mul_alpha(w1_q);
               w2_d    = gf_mul_alpha2(w2_q);
               if (cnt_q == LAST_CNT) state_d = PARITY;
               else                   cnt_d   = cnt_q + 6'd1;
            end
         end
         PARITY: begin
            // P2 leaving the register closes the codeword; otherwise refill
            if (fire && last_q) begin
               state_d = DATA;
               cnt_d   = '0;
               acc0_d  = '0;
               acc1_d  = '0;
               acc2_d  = '0;
               w1_d    = 8'h01;
               w2_d    = 8'h01;
               psel_d  = '0;
               busy_d  = 1'b0;
            end else if (free && psel_q != 2'd3) begin
               code_d  = par_sym;
               idx_d   = PAR_IDX0 + {4'b0, psel_q};
               valid_d = 1'b1;
               last_d  = (psel_q == 2'd2);
               psel_d  = psel_q + 2'd1;
            end
         end
         default: ;
      endcase

      if (Clear_in) begin
         state_d = DATA;
         cnt_d   = '0;
         acc0_d  = '0;
         acc1_d  = '0;
         acc2_d  = '0;
         w1_d    = 8'h01;
         w2_d    = 8'h01;
         psel_d  = '0;
         code_d  = '0;
         idx_d   = '0;
         valid_d = 1'b0;
         last_d  = 1'b0;
         busy_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DATA;
         cnt_q   <= '0;
         acc0_q  <= '0;
         acc1_q  <= '0;
         acc2_q  <= '0;
         w1_q    <= 8'h01;
         w2_q    <= 8'h01;
         psel_q  <= '0;
         code_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc0_q  <= acc0_d;
         acc1_q  <= acc1_d;
         acc2_q  <= acc2_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         psel_q  <= psel_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.Data_ready_out = data_ready;
   assign bus.Code_out       = code_q;
   assign bus.Code_index_out = idx_q;
   assign bus.Code_valid_out = valid_q;
   assign bus.Code_last_out  = last_q;
   assign bus.Busy_out       = busy_q;

endmodule

// File: tb/tb_ssc_dsd_stream_encoder.sv
// Self-checking bench for ssc_dsd_stream_encoder: random data and stalls
// against a polynomial-arithmetic parity model, plus clear and reset cases.
module tb_ssc_dsd_stream_encoder;

   localparam int DS = 36;

   typedef struct packed {
      logic [7:0] sym;
      logic [5:0] idx;
      logic       last;
   } exp_t;

   logic clk;
   logic rst_n;
   logic Clear_in;
   ssc_dsd_stream_encoder_if bus ();

   ssc_dsd_stream_encoder #(.DATA_SYMS(DS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Clear_in (Clear_in),
      .bus      (bus)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   exp_t       exp_q[$];
   exp_t       e;
   logic [7:0] cw_data [DS];
   logic [7:0] par_seen [3];
   int         rdy_mode = 0;
   bit         mon_en = 0;
   bit         hold_v = 0;
   exp_t       held;
   int         cyc = 0;
   int         first_cyc = 0;
   int         span = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // GF(2^8) product by carry-less multiply and polynomial long division
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h015F << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] gpow(input int ex);
      logic [7:0] r = 8'h01;
      for (int k = 0; k < ex; k++) r = gmul(r, 8'h02);
      return r;
   endfunction

   // Code_ready_in driver: 0 = always ready, 1 = random, 2 = held off
   initial begin
      bus.Code_ready_in = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       bus.Code_ready_in = 1'b1;
            1:       bus.Code_ready_in = 1'($urandom_range(0, 1));
            default: bus.Code_ready_in = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!mon_en || !rst_n) begin
         hold_v = 0;
      end else begin
         if (hold_v) begin
            check_eq("hold_code", 32'(bus.Code_out), 32'(held.sym));
            check_eq("hold_index", 32'(bus.Code_index_out), 32'(held.idx));
            check_eq("hold_last", 32'(bus.Code_last_out), 32'(held.last));
         end
         if (bus.Code_valid_out && bus.Code_ready_in) begin
            hold_v = 0;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_symbol", 32'(bus.Code_index_out), 32'hFFFF);
            end else begin
               e = exp_q.pop_front();
               check_eq("code", 32'(bus.Code_out), 32'(e.sym));
               check_eq("index", 32'(bus.Code_index_out), 32'(e.idx));
               check_eq("last", 32'(bus.Code_last_out), 32'(e.last));
               check_eq("busy_in_cw", 32'(bus.Busy_out), 32'd1);
               if (e.idx == 6'd0) first_cyc = cyc;
               if (e.idx >= 6'd36) par_seen[e.idx - 6'd36] = bus.Code_out;
               if (e.last) span = cyc - first_cyc;
            end
         end else if (bus.Code_valid_out) begin
            hold_v = 1;
            held   = '{sym: bus.Code_out, idx: bus.Code_index_out, last: bus.Code_last_out};
         end else begin
            hold_v = 0;
         end
      end
   end

   task automatic drive_syms(input int n, input bit stall);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 2000) begin
         bus.Data_in       = cw_data[i];
         bus.Data_valid_in = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         if (bus.Data_valid_in && bus.Data_ready_out) i++;
         @(posedge clk);
         #1;
         guard++;
      end
      bus.Data_valid_in = 1'b0;
      check_eq("drive_done", 32'(i), 32'(n));
   endtask

   task automatic send_cw(input bit stall);
      logic [7:0] p0 = '0;
      logic [7:0] p1 = '0;
      logic [7:0] p2 = '0;
      for (int i = 0; i < DS; i++) begin
         exp_q.push_back('{sym: cw_data[i], idx: 6'(i), last: 1'b0});
         p0 = p0 ^ cw_data[i];
         p1 = p1 ^ gmul(cw_data[i], gpow(i));
         p2 = p2 ^ gmul(cw_data[i], gpow(2 * i));
      end
      exp_q.push_back('{sym: p0, idx: 6'd36, last: 1'b0});
      exp_q.push_back('{sym: p1, idx: 6'd37, last: 1'b0});
      exp_q.push_back('{sym: p2, idx: 6'd38, last: 1'b1});
      drive_syms(DS, stall);
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 5000) begin
         @(posedge clk);
         #1;
         g++;
      end
      check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
      check_eq("idle_busy", 32'(bus.Busy_out), 32'd0);
      check_eq("idle_valid", 32'(bus.Code_valid_out), 32'd0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < DS; i++) cw_data[i] = 8'($urandom);
   endtask

   task automatic fill_single(input int pos, input logic [7:0] v);
      for (int i = 0; i < DS; i++) cw_data[i] = '0;
      cw_data[pos] = v;
   endtask

   task automatic check_parity(input string tag, input logic [23:0] want);
      check_eq({tag, "_P0"}, 32'(par_seen[0]), 32'(want[23:16]));
      check_eq({tag, "_P1"}, 32'(par_seen[1]), 32'(want[15:8]));
      check_eq({tag, "_P2"}, 32'(par_seen[2]), 32'(want[7:0]));
   endtask

   initial begin
      #500000;
      n_errors++;
      $display("FAIL watchdog: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.Data_in       = '0;
      bus.Data_valid_in = 1'b0;
      Clear_in          = 1'b0;
      rst_n             = 1'b0;
      #12;
      check_eq("rst_code", 32'(bus.Code_out), 32'd0);
      check_eq("rst_index", 32'(bus.Code_index_out), 32'd0);
      check_eq("rst_valid", 32'(bus.Code_valid_out), 32'd0);
      check_eq("rst_last", 32'(bus.Code_last_out), 32'd0);
      check_eq("rst_busy", 32'(bus.Busy_out), 32'd0);
      check_eq("rst_ready", 32'(bus.Data_ready_out), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1;

      // Directed: all-zero codeword with continuous flow, no bubbles
      fill_single(0, 8'h00);
      send_cw(0);
      drain();
      check_parity("zero", 24'h000000);
      check_eq("zero_span", 32'(span), 32'd38);

      fill_single(0, 8'h80);
      send_cw(0);
      drain();
      check_parity("d0_80", 24'h808080);

      fill_single(1, 8'h80);
      send_cw(0);
      drain();
      check_parity("d1_80", 24'h805FBE);

      fill_single(2, 8'h01);
      send_cw(0);
      drain();
      check_parity("d2_01", 24'h010410);

      // Random data with stalls on both sides
      rdy_mode = 1;
      for (int k = 0; k < 6; k++) begin
         fill_random();
         send_cw(1);
         drain();
      end

      // Clear coincident with the 21st accept
      mon_en   = 0;
      rdy_mode = 0;
      @(posedge clk);
      #1;
      fill_random();
      drive_syms(20, 0);
      bus.Data_in       = 8'hA5;
      bus.Data_valid_in = 1'b1;
      Clear_in          = 1'b1;
      @(negedge clk);
      check_eq("clr_ready_offered", 32'(bus.Data_ready_out), 32'd1);
      @(posedge clk);
      #1;
      Clear_in          = 1'b0;
      bus.Data_valid_in = 1'b0;
      check_eq("clr_valid", 32'(bus.Code_valid_out), 32'd0);
      check_eq("clr_index", 32'(bus.Code_index_out), 32'd0);
      check_eq("clr_busy", 32'(bus.Busy_out), 32'd0);
      check_eq("clr_ready", 32'(bus.Data_ready_out), 32'd1);
      exp_q.delete();
      mon_en   = 1;
      rdy_mode = 1;
      fill_random();
      send_cw(1);
      drain();

      // Reset while P1 is held under backpressure
      mon_en   = 0;
      rdy_mode = 0;
      @(posedge clk);
      #1;
      fill_random();
      drive_syms(DS, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rdy_mode = 2;
      #2;
      check_eq("bp_p1_index", 32'(bus.Code_index_out), 32'd37);
      check_eq("bp_p1_valid", 32'(bus.Code_valid_out), 32'd1);
      @(posedge clk);
      #3;
      check_eq("bp_p1_held", 32'(bus.Code_index_out), 32'd37);
      rst_n = 1'b0;
      #1;
      check_eq("arst_code", 32'(bus.Code_out), 32'd0);
      check_eq("arst_index", 32'(bus.Code_index_out), 32'd0);
      check_eq("arst_valid", 32'(bus.Code_valid_out), 32'd0);
      check_eq("arst_last", 32'(bus.Code_last_out), 32'd0);
      check_eq("arst_busy", 32'(bus.Busy_out), 32'd0);
      check_eq("arst_ready", 32'(bus.Data_ready_out), 32'd1);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rdy_mode = 1;
      exp_q.delete();
      mon_en = 1;
      fill_random();
      send_cw(1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ssc_dsd_stream_encoder.md
Name: ssc_dsd_stream_encoder

Overview:
- Streaming systematic encoder for the SSC-DSD Reed-Solomon code over GF(2^8).
- Primitive polynomial is x^8+x^6+x^4+x^3+x^2+x+1 (0x15F).
- Accepts 36 data symbols, one per handshake. It forwards them unchanged, then appends 3 parity symbols, P0, P1 and P2.
- This is the write-side counterpart of the syndrome/error-information decoder. Codeword symbol index 0..38 matches the decoder's error-location numbering.

Parameters:
- DATA_SYMS, 36, number of data symbols per codeword. Legal range is 1..36.
- SYM_W, 8, symbol width. Fixed by the field; no other value is supported.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- Clear_in  input  1  synchronous abort of the current codeword
- Data_in  input  8  data symbol
- Data_valid_in  input  1  Data_in is valid
- Data_ready_out  output  1  encoder can accept a data symbol
- Code_out  output  8  codeword symbol, data or parity
- Code_index_out  output  6  symbol index, 0..38
- Code_valid_out  output  1  Code_out is valid
- Code_ready_in  input  1  downstream accepts Code_out
- Code_last_out  output  1  high with index 38 (P2)
- Busy_out  output  1  a codeword is in progress

Behaviour:
- Parity definitions, for data symbols d_i with i = 0..35:
  - P0 = XOR of d_i
  - P1 = XOR of d_i*alpha^i
  - P2 = XOR of d_i*alpha^(2i)
  - All three syndromes of the resulting codeword are 0.
- Handshakes: accept = Data_valid_in & Data_ready_out; fire = Code_valid_out & Code_ready_in.
- Output register: a single register drives Code_out, Code_index_out, Code_valid_out and Code_last_out.
  - It may load only when it is empty or firing in the same cycle.
  - Outputs hold stable while Code_valid_out=1 and Code_ready_in=0.
- State DATA:
  - Data_ready_out = !Code_valid_out | Code_ready_in.
  - On accept, the output register takes Data_in with index = data counter. In the same cycle:
    - acc0 ^= d
    - acc1 ^= d*w1, then w1 *= alpha
    - acc2 ^= d*w2, then w2 *= alpha^2
  - On the accept with counter = DATA_SYMS-1, move to PARITY. The accumulators then hold the final P0..P2.
- State PARITY:
  - Data_ready_out = 0.
  - Each time the output register is free (empty, or firing), load the next parity symbol: P0 (index 36), then P1 (37), then P2 (38).
  - Code_last_out is asserted with P2.
  - When P2 fires, clear acc0..acc2, set w1=w2=0x01 and counter=0, and return to DATA.
- Latency:
  - A data symbol appears on Code_out in the cycle after it is accepted.
  - P0 appears in the cycle after data symbol 35 fires, or the cycle after it is accepted if the register is already free.
  - With continuous ready, one symbol is emitted per cycle, giving 39 cycles per codeword with no bubble.
- Busy_out = 1 from the first accept until P2 fires.
- Reset (rst_n=0, asynchronous):
  - State is DATA; counter=0; acc0..acc2=0; w1=w2=0x01.
  - Code_out=0, Code_index_out=0, Code_valid_out=0, Code_last_out=0, Busy_out=0.
  - After reset Data_ready_out=1, since it is combinational on an empty register.
  - A reset in the middle of a codeword discards that codeword entirely.
- Clear_in=1 has the same effect as reset on the next edge and overrides any simultaneous accept or fire.
- Counter width is 6 bits. The data counter never exceeds DATA_SYMS-1, and the symbol index never exceeds 38.
- Arithmetic:
  - Constant multiplication by alpha: shift left, then XOR with 0x5F if bit 7 was set.
  - alpha^2 is two such steps.

Decomposition:
- Package ssc_dsd_pkg holds:
  - SYM_W, DATA_SYMS, PARITY_SYMS=3, CW_SYMS=39
  - GF_POLY=9'h15F
  - typedef sym_t (logic [7:0])
  - the state enum {DATA, PARITY}
  - functions gf_mul_alpha and gf_mul_alpha2
- Sub-module gf_mul: a combinational general GF(2^8) multiplier. It is instantiated twice, for d*w1 and d*w2.

Test Plan:
- All 36 data = 0x00 with continuous ready -> 39 symbols out; P0=P1=P2=0x00; Code_last_out high only at index 38.
- d0=0x80, all others 0 -> P0=P1=P2=0x80.
- d1=0x80, all others 0 -> P0=0x80, P1=0x5F, P2=0xBE. Separately, d2=0x01 -> P0=0x01, P1=0x04, P2=0x10.
- Random data with random Code_ready_in/Data_valid_in stalls -> Code_out stable while stalled. Data is forwarded in order, and parity matches a reference model. Feeding the codeword to the decoder gives NE for every codeword.
- Clear_in asserted after 20 accepts, coincident with an accept -> that accept is dropped, Code_valid_out=0, counter=0. The next codeword's parity covers only the new data.
- rst_n pulsed low while P1 is held under backpressure -> all outputs 0 immediately. After release, Data_ready_out=1 and the next codeword encodes correctly.
